bpm_tick_generator: RTL

//  Converts a BPM setting into a one-cycle beat pulse train (o_tick) for the metronome.

---
 rtl/bpm_tick_generator.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/bpm_tick_generator.sv
// Beat pulse generator: serial restoring divider turns a BPM into a period in clock cycles.
// Optional bar accent counter (o_beat_idx / o_downbeat) enabled by defining BPM_TICK_ACCENT_EN.
module bpm_tick_generator #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned BPM_W       = 9,
  parameter int unsigned BPM_MIN     = 30,
  parameter int unsigned BPM_MAX     = 300,
  parameter int unsigned DEFAULT_BPM = 120
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [BPM_W-1:0] i_bpm,
  input  logic             i_bpm_valid,
  output logic             o_bpm_ready,
  input  logic [2:0]       i_beats_per_bar,
  output logic             o_tick,
  output logic             o_downbeat,
  output logic [2:0]       o_beat_idx,
  output logic [31:0]      o_period
);

  localparam logic [31:0]      DIVIDEND       = 32'(CLK_FREQ_HZ * 32'd60);
  localparam logic [31:0]      DEFAULT_PERIOD = DIVIDEND / 32'(DEFAULT_BPM);
  localparam logic [BPM_W-1:0] BPM_MIN_V      = BPM_W'(BPM_MIN);
  localparam logic [BPM_W-1:0] BPM_MAX_V      = BPM_W'(BPM_MAX);

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;
  typedef enum logic {TICK_STOP, TICK_RUN} tick_state_t;

  div_state_t       div_state_q, div_state_d;
  tick_state_t      tick_state_q, tick_state_d;
  logic [4:0]       div_cnt_q, div_cnt_d;
  logic [31:0]      divisor_q, divisor_d;
  logic [31:0]      rem_q, rem_d;
  logic [31:0]      quo_q, quo_d;
  logic             ready_q, ready_d;
  logic [31:0]      period_q, period_d;
  logic [31:0]      phase_q, phase_d;
  logic             tick_q, tick_d;
  logic             restart;
  logic [BPM_W-1:0] bpm_clamped;
  logic [32:0]      rem_shift;
  logic [32:0]      diff;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      div_state_q  <= DIV_IDLE;
      tick_state_q <= TICK_STOP;
      div_cnt_q    <= '0;
      divisor_q    <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      ready_q      <= 1'b1;
      period_q     <= DEFAULT_PERIOD;
      phase_q      <= '0;
      tick_q       <= 1'b0;
    end else begin
      div_state_q  <= div_state_d;
      tick_state_q <= tick_state_d;
      div_cnt_q    <= div_cnt_d;
      divisor_q    <= divisor_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      ready_q      <= ready_d;
      period_q     <= period_d;
      phase_q      <= phase_d;
      tick_q       <= tick_d;
    end
  end

  always_comb begin
    div_state_d = div_state_q;
    div_cnt_d   = div_cnt_q;
    divisor_d   = divisor_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    bpm_clamped = i_bpm;
    if (i_bpm < BPM_MIN_V) bpm_clamped = BPM_MIN_V;
    else if (i_bpm > BPM_MAX_V) bpm_clamped = BPM_MAX_V;
    // Borrow out of the 33-bit trial subtraction doubles as the "fits" test.
    rem_shift = {rem_q, quo_q[31]};
    diff      = rem_shift - {1'b0, divisor_q};

    unique case (div_state_q)
      DIV_IDLE: begin
        if (i_bpm_valid && ready_q) begin
          divisor_d   = 32'(bpm_clamped);
          rem_d       = '0;
          quo_d       = DIVIDEND;
          div_cnt_d   = '0;
          div_state_d = DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        if (!diff[32]) begin
          rem_d = diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = rem_shift[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        div_cnt_d = div_cnt_q + 5'd1;
        if (div_cnt_q == 5'd31) div_state_d = DIV_DONE;
      end
      DIV_DONE: div_state_d = DIV_IDLE;
      default:  div_state_d = DIV_IDLE;
    endcase
    ready_d = (div_state_d == DIV_IDLE);
  end

  always_comb begin
    tick_state_d = tick_state_q;
    phase_d      = phase_q;
    period_d     = period_q;
    tick_d       = 1'b0;
    restart      = 1'b0;
    if (!i_enable) begin
      tick_state_d = TICK_STOP;
      phase_d      = '0;
    end else if (tick_state_q == TICK_STOP) begin
      tick_state_d = TICK_RUN;
      phase_d      = '0;
      tick_d       = 1'b1;
      restart      = 1'b1;
    end else if (phase_q == period_q - 32'd1) begin
      phase_d = '0;
      tick_d  = 1'b1;
    end else begin
      phase_d = phase_q + 32'd1;
    end
    // Commit overrides any wrap in the same cycle so only one tick is issued.
    if (div_state_q == DIV_DONE) begin
      period_d = quo_q;
      phase_d  = '0;
      if (i_enable) begin
        tick_d  = 1'b1;
        restart = 1'b1;
      end
    end
  end

  assign o_tick      = tick_q;
  assign o_period    = period_q;
  assign o_bpm_ready = ready_q;

`ifdef BPM_TICK_ACCENT_EN
  logic [2:0] beat_idx_q, beat_idx_d;
  logic       downbeat_q, downbeat_d;
  logic [2:0] beats_n;
  logic [2:0] idx_inc;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      beat_idx_q <= '0;
      downbeat_q <= 1'b0;
    end else begin
      beat_idx_q <= beat_idx_d;
      downbeat_q <= downbeat_d;
    end
  end

  always_comb begin
    beat_idx_d = beat_idx_q;
    downbeat_d = 1'b0;
    beats_n    = (i_beats_per_bar == 3'd0) ? 3'd4 : i_beats_per_bar;
    idx_inc    = beat_idx_q + 3'd1;
    if (!i_enable) begin
      beat_idx_d = '0;
    end else if (tick_d) begin
      if (restart || idx_inc >= beats_n) beat_idx_d = '0;
      else beat_idx_d = idx_inc;
      downbeat_d = (beat_idx_d == 3'd0);
    end
  end

  assign o_beat_idx = beat_idx_q;
  assign o_downbeat = downbeat_q;
`else
  logic unused_beats_per_bar;
  assign unused_beats_per_bar = ^i_beats_per_bar;
  assign o_beat_idx = '0;
  assign o_downbeat = 1'b0;
`endif

endmodule
